// File: rtl/roi_frame_loader.sv
// Streams one raster frame from an FWFT input FIFO into frame BRAM and forwards pixels inside a programmable ROI.
// Zero-latency pop/write on accept; stalls only when an in-ROI pixel meets a full output FIFO.
module roi_frame_loader #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720,
  parameter int PIX_W  = 24,
  parameter int ADDR_W = $clog2(WIDTH * HEIGHT),
  parameter int XW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  parameter int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  parameter int CNT_W  = $clog2(WIDTH * HEIGHT + 1),
  parameter logic [XW-1:0] DEF_X0 = '0,
  parameter logic [XW-1:0] DEF_X1 = XW'(WIDTH - 1),
  parameter logic [YW-1:0] DEF_Y0 = '0,
  parameter logic [YW-1:0] DEF_Y1 = YW'(HEIGHT - 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_wr_en,
  input  logic [XW-1:0]     cfg_x0,
  input  logic [XW-1:0]     cfg_x1,
  input  logic [YW-1:0]     cfg_y0,
  input  logic [YW-1:0]     cfg_y1,
  output logic              in_rd_en,
  input  logic              in_empty,
  input  logic [PIX_W-1:0]  in_dout,
  output logic              fifo_out_wr_en,
  input  logic              fifo_out_full,
  output logic [PIX_W-1:0]  fifo_out_din,
  output logic              bram_out_wr_en,
  output logic [ADDR_W-1:0] bram_out_wr_addr,
  output logic [PIX_W-1:0]  bram_out_wr_data,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic [CNT_W-1:0]  roi_count,
  output logic              cfg_error
);

  typedef struct packed {
    logic [XW-1:0] x0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y0;
    logic [YW-1:0] y1;
  } roi_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [XW:0]   X_LIM  = (XW + 1)'(WIDTH);
  localparam logic [YW:0]   Y_LIM  = (YW + 1)'(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam roi_t          DEF_ROI = '{x0: DEF_X0, x1: DEF_X1, y0: DEF_Y0, y1: DEF_Y1};

  state_t            state;
  roi_t              pend_roi;
  roi_t              act_roi;
  logic              act_ok;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  acc;
  logic              hit;
  logic              accept;

  // The x1/y1 limit checks matter only when WIDTH/HEIGHT are not powers of two.
  function automatic logic roi_ok(input roi_t r);
    return (r.x0 <= r.x1) && (r.y0 <= r.y1) &&
           ({1'b0, r.x1} < X_LIM) && ({1'b0, r.y1} < Y_LIM);
  endfunction

  always_comb begin
    hit              = 1'b0;
    accept           = 1'b0;
    in_rd_en         = 1'b0;
    bram_out_wr_en   = 1'b0;
    bram_out_wr_addr = '0;
    bram_out_wr_data = '0;
    fifo_out_wr_en   = 1'b0;
    fifo_out_din     = '0;
    if (state == STREAM) begin
      hit    = act_ok && (x >= act_roi.x0) && (x <= act_roi.x1) &&
               (y >= act_roi.y0) && (y <= act_roi.y1);
      // Only an in-ROI pixel can be held back by the output FIFO.
      accept = !in_empty && !(hit && fifo_out_full);
      if (accept) begin
        in_rd_en         = 1'b1;
        bram_out_wr_en   = 1'b1;
        bram_out_wr_addr = addr;
        bram_out_wr_data = in_dout;
        if (hit) begin
          fifo_out_wr_en = 1'b1;
          fifo_out_din   = in_dout;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pend_roi    <= DEF_ROI;
      act_roi     <= DEF_ROI;
      act_ok      <= 1'b1;
      x           <= '0;
      y           <= '0;
      addr        <= '0;
      acc         <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      roi_count   <= '0;
      cfg_error   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (cfg_wr_en) begin
        pend_roi <= '{x0: cfg_x0, x1: cfg_x1, y0: cfg_y0, y1: cfg_y1};
      end
      case (state)
        IDLE: begin
          if (!in_empty) begin
            act_roi   <= pend_roi;
            act_ok    <= roi_ok(pend_roi);
            cfg_error <= !roi_ok(pend_roi);
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            acc       <= '0;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            addr <= addr + 1'b1;
            if (hit) begin
              acc <= acc + 1'b1;
            end
            if (x == X_LAST) begin
              x <= '0;
              if (y == Y_LAST) begin
                y          <= '0;
                frame_done <= 1'b1;
                state      <= DONE;
              end else begin
                y <= y + 1'b1;
              end
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        DONE: begin
          frame_count <= frame_count + 16'd1;
          roi_count   <= acc;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
